// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and types for the IF-stage fetch address generator.
package fetch_pc_gen_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;
    localparam int          INSN_WIDTH       = 32;
    localparam int          MAX_FETCH_WIDTH  = 4;

    // Encoded so that a numerically larger code always has the higher priority.
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_BR   = 2'd1,
        REDIR_ERTN = 2'd2,
        REDIR_EXCP = 2'd3
    } redirect_e;

    typedef struct packed {
        logic [31:0]                           pc;
        logic [MAX_FETCH_WIDTH*INSN_WIDTH-1:0] data;
        logic [MAX_FETCH_WIDTH-1:0]            mask;
    } fetch_bundle_t;

    function automatic redirect_e redirect_select(input logic excp, input logic ertn, input logic br);
        if (excp) return REDIR_EXCP;
        if (ertn) return REDIR_ERTN;
        if (br)   return REDIR_BR;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_pc_queue.sv
// In-order FIFO of outstanding fetch PCs; the head is the PC of the next expected response.
module fetch_pc_gen_pc_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [31:0]                push_pc,
    input  logic                       pop,
    output logic [31:0]                head_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head_pc = entries[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_pc;
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch address generator: issues aligned block fetches, pairs responses with their PC,
// and discards wrong-path responses after a redirect.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          FETCH_WIDTH = 2,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              excp_flush,
    input  logic [31:0]                       eentry,
    input  logic                              ertn_flush,
    input  logic [31:0]                       era,
    input  logic                              br_taken,
    input  logic [31:0]                       br_target,
    output logic                              req_valid,
    input  logic                              req_ready,
    output logic [31:0]                       req_pc,
    input  logic                              resp_valid,
    output logic                              resp_ready,
    input  logic [INSN_WIDTH*FETCH_WIDTH-1:0] resp_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_pc,
    output logic [INSN_WIDTH*FETCH_WIDTH-1:0] out_data,
    output logic [FETCH_WIDTH-1:0]            out_mask
);

    localparam int          CNT_W       = $clog2(QUEUE_DEPTH) + 1;
    localparam int          BLOCK_BYTES = FETCH_WIDTH * 4;
    localparam logic [31:0] OFFSET_MASK = 32'(BLOCK_BYTES - 1);
    localparam logic [31:0] BLOCK_STEP  = 32'(BLOCK_BYTES);

    logic [31:0]      pc;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] inflight;
    logic [31:0]      head_pc;
    logic [31:0]      head_lane;
    logic [31:0]      redirect_raw;
    logic [31:0]      redirect_target;
    redirect_e        redir_sel;
    logic             redirect;
    logic             draining;
    logic             req_fire;
    logic             resp_fire;
    logic             queue_pop;

    assign redir_sel = redirect_select(excp_flush, ertn_flush, br_taken);
    assign redirect  = (redir_sel != REDIR_NONE);

    always_comb begin
        case (redir_sel)
            REDIR_EXCP: redirect_raw = eentry;
            REDIR_ERTN: redirect_raw = era;
            default:    redirect_raw = br_target;
        endcase
    end

    assign redirect_target = {redirect_raw[31:2], 2'b00};

    // Every handshake output is forced low while reset is held, independent of the clock.
    assign draining   = (drop_cnt != '0);
    assign req_valid  = reset && !redirect && (inflight < CNT_W'(QUEUE_DEPTH));
    assign req_fire   = req_valid && req_ready;
    assign req_pc     = pc;
    assign resp_ready = reset && ((redirect || draining) ? 1'b1 : out_ready);
    assign resp_fire  = resp_valid && resp_ready;
    assign queue_pop  = resp_fire && (inflight != '0);
    assign out_valid  = reset && resp_valid && !redirect && !draining;
    assign out_pc     = head_pc;
    assign out_data   = resp_data;
    assign head_lane  = (head_pc & OFFSET_MASK) >> 2;

    always_comb begin
        out_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            out_mask[i] = reset && (32'(i) >= head_lane);
        end
    end

    fetch_pc_gen_pc_queue #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .reset   (reset),
        .push    (req_fire),
        .push_pc (pc),
        .pop     (queue_pop),
        .head_pc (head_pc),
        .count   (inflight)
    );

    // On redirect every entry still queued after this cycle's pop belongs to the old path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            pc       <= redirect_target;
            drop_cnt <= inflight - CNT_W'(queue_pop);
        end else begin
            if (req_fire) pc <= (pc & ~OFFSET_MASK) + BLOCK_STEP;
            if (queue_pop && draining) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) resp_fire |-> (inflight != '0));

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Parametrised fetch-address generator for the IF stage. Produces aligned multi-instruction fetch requests and tracks outstanding requests in an in-order PC queue. Pairs each instruction-memory response with its PC and a lane-valid mask, then hands the bundle to ID. Applies exception, ertn and branch redirects, and discards responses belonging to the wrong path.

Parameters:
RESET_PC, 32'h1C000000, PC loaded at reset
FETCH_WIDTH, 2, instructions per fetch block (1, 2 or 4)
QUEUE_DEPTH, 4, maximum outstanding requests (power of 2, at least 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
excp_flush  in  1  exception redirect
eentry  in  32  exception entry target
ertn_flush  in  1  ertn redirect
era  in  32  ertn return target
br_taken  in  1  branch/jump redirect
br_target  in  32  branch target
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts request
req_pc  out  32  fetch PC (word-aligned)
resp_valid  in  1  memory response valid
resp_ready  out  1  response consumed
resp_data  in  32*FETCH_WIDTH  instructions, lane 0 in low bits
out_valid  out  1  bundle valid to ID
out_ready  in  1  ID accepts bundle
out_pc  out  32  PC of the bundle's first valid lane
out_data  out  32*FETCH_WIDTH  instructions
out_mask  out  FETCH_WIDTH  lane valid bits

Behaviour:
- Block size B = FETCH_WIDTH*4 bytes. Lane offset L = pc[log2(B)-1:2] (0 when FETCH_WIDTH=1).
- During reset: pc=RESET_PC, inflight=0, drop_cnt=0, queue empty. Outputs: req_valid=0, out_valid=0, resp_ready=0, req_pc=RESET_PC, out_mask=0.
- Redirect priority: excp_flush > ertn_flush > br_taken. Target bits [1:0] are forced to 0. pc loads the target on the next edge.
- req_valid = !redirect && (inflight < QUEUE_DEPTH). This is combinational on the flush inputs. Request fires when req_valid && req_ready.
- On request fire: push req_pc into the queue and set pc <= (pc & ~(B-1)) + B. pc holds otherwise. A redirect overrides the increment.
- Response handling:
  - resp_ready = (redirect || drop_cnt!=0) ? 1 : out_ready.
  - out_valid = resp_valid && !redirect && drop_cnt==0.
  - Response fire pops the queue head. out_pc = head PC and out_data = resp_data, both combinational.
  - out_mask bit i = (i >= L of head PC).
- Drop: a response fire with drop_cnt!=0 decrements drop_cnt and produces no output.
- On redirect: drop_cnt <= inflight minus 1 if a response fires this cycle (all remaining entries are stale). Later responses are dropped until drop_cnt reaches 0.
- inflight tracks the queue count. A push and a pop in the same cycle leave it unchanged.
- Queue full: no request issues. A pop in the same cycle does not enable a push that cycle; the push waits one cycle.
- Response when queue empty: protocol violation. Assert in simulation; RTL ignores it.
- Back-to-back redirects: the latest wins, and drop_cnt is recomputed each time.
- Async reset mid-operation: all state clears immediately. In-flight memory responses after reset are the memory's responsibility (it is reset too).
- Latency: redirect at cycle n gives req_pc=target at n+1. A response is forwarded in the same cycle it arrives.

Decomposition:
- Shared package (defines.sv): RESET_PC default, instruction width constant, redirect priority encoding, fetch-bundle struct {pc, data, mask}.
- One sub-module: pc_queue, a synchronous FIFO with parametrised depth, 32-bit entries, push/pop and count output.
- Lane-mask and alignment logic stays in the top level.

Test Plan:
1. Reset release with req_ready=1 and a 1-cycle response memory -> req_pc 1C000000, 1C000008, 1C000010 on consecutive cycles; out_mask=2'b11; out_pc matches in order.
2. br_taken to 1C000104 while 2 requests are in flight -> both responses dropped (out_valid=0). Next req_pc=1C000104 with out_mask=2'b10 and out_pc=1C000104, then 1C000108 with mask 2'b11.
3. resp_valid held 0, req_ready=1 -> exactly 4 requests issue, then req_valid=0. One response fires -> one more request follows a cycle later.
4. excp_flush (eentry=1C008000), ertn_flush and br_taken all in the same cycle -> next req_pc=1C008000 and drop_cnt equals inflight.
5. out_ready=0 with resp_valid=1 -> resp_ready=0, out_data stable, inflight unchanged. Release out_ready -> bundle transfers once.
6. Assert reset mid-stream with 3 in flight -> out_valid and req_valid drop immediately and inflight=0. On release, req_pc=1C000000.
